// File: rtl/instr_sequencer.sv
// Program sequencer: fetches {opcode,operand} from a synchronous ROM and issues one instruction per slot.
// Latency: FETCH->LATCH->EXEC, so 3 cycles per instruction and 2 cycles from fetch to instr_valid.
// Backpressure: f_wait parks the sequencer in WAIT until a sample strobe (live or pending) releases it.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, stop         start program at pc=0 (IDLE only); synchronous abort to IDLE (wins over start)
//   sample_stb          one-cycle strobe releasing WAIT
//   imem_rd, imem_addr  ROM read request; imem_data returns one cycle later
//   f_wait              decoder request to park after the current instruction (sampled in EXEC)
//   opcode, operand     registered instruction word; NOP_OPCODE/0 when idle or waiting
//   instr_valid         one-cycle pulse per issued instruction
//   pc, busy, overrun   current/next address, not-IDLE flag, sticky lost-strobe flag
module instr_sequencer #(
    parameter int                    OPCODE_WIDTH  = 3,
    parameter int                    OPERAND_WIDTH = 8,
    parameter int                    ADDR_WIDTH    = 6,
    parameter int                    PROG_LEN      = 64,
    parameter logic [OPCODE_WIDTH-1:0] NOP_OPCODE  = 3'b111
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  stop,
    input  logic                                  sample_stb,
    output logic                                  imem_rd,
    output logic [ADDR_WIDTH-1:0]                 imem_addr,
    input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] imem_data,
    input  logic                                  f_wait,
    output logic [OPCODE_WIDTH-1:0]               opcode,
    output logic [OPERAND_WIDTH-1:0]              operand,
    output logic                                  instr_valid,
    output logic [ADDR_WIDTH-1:0]                 pc,
    output logic                                  busy,
    output logic                                  overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_WAIT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(PROG_LEN - 1);

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     pc_q, pc_d, pc_inc;
    logic [ADDR_WIDTH-1:0]     imem_addr_q, imem_addr_d;
    logic                      imem_rd_q, imem_rd_d;
    logic [OPCODE_WIDTH-1:0]   opcode_q, opcode_d;
    logic [OPERAND_WIDTH-1:0]  operand_q, operand_d;
    logic                      instr_valid_q, instr_valid_d;
    logic                      busy_q, busy_d;
    logic                      pending_q, pending_d;
    logic                      overrun_q, overrun_d;
    logic                      consumed;
    logic                      clear_flags;

    assign pc_inc = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        opcode_d      = opcode_q;
        operand_d     = operand_q;
        instr_valid_d = 1'b0;
        imem_rd_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        consumed      = 1'b0;
        clear_flags   = 1'b0;

        if (stop) begin
            // pc and overrun deliberately survive an abort so software can inspect them.
            state_d   = S_IDLE;
            opcode_d  = NOP_OPCODE;
            operand_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d     = S_FETCH;
                        pc_d        = '0;
                        clear_flags = 1'b1;
                    end
                end
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    state_d       = S_EXEC;
                    opcode_d      = imem_data[OPCODE_WIDTH+OPERAND_WIDTH-1:OPERAND_WIDTH];
                    operand_d     = imem_data[OPERAND_WIDTH-1:0];
                    instr_valid_d = 1'b1;
                end
                S_EXEC: begin
                    if (f_wait) begin
                        state_d   = S_WAIT;
                        opcode_d  = NOP_OPCODE;
                        operand_d = '0;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_inc;
                    end
                end
                S_WAIT: begin
                    if (pending_q || sample_stb) begin
                        state_d  = S_FETCH;
                        pc_d     = pc_inc;
                        consumed = 1'b1;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    opcode_d  = NOP_OPCODE;
                    operand_d = '0;
                end
            endcase
        end

        // Read request and address are registered on entry to FETCH so the ROM
        // sees them for the whole FETCH cycle and returns data during LATCH.
        if (state_d == S_FETCH) begin
            imem_rd_d   = 1'b1;
            imem_addr_d = pc_d;
        end

        busy_d = (state_d != S_IDLE);

        // One-deep strobe counter: pending + sample_stb - consumed, saturating at 1.
        // A would-be count of 2 means a strobe was lost.
        if (clear_flags) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end else if (consumed) begin
            pending_d = pending_q & sample_stb;
            overrun_d = overrun_q;
        end else begin
            pending_d = pending_q | sample_stb;
            overrun_d = overrun_q | (pending_q & sample_stb);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            imem_addr_q   <= '0;
            imem_rd_q     <= 1'b0;
            opcode_q      <= NOP_OPCODE;
            operand_q     <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_addr_q   <= imem_addr_d;
            imem_rd_q     <= imem_rd_d;
            opcode_q      <= opcode_d;
            operand_q     <= operand_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
        end
    end

    assign imem_rd     = imem_rd_q;
    assign imem_addr   = imem_addr_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule
